// File: rtl/maze_move_checker_pkg.sv
// Shared constants, direction codes and FSM state type for the maze move checker.
package maze_pkg;

    localparam int unsigned SPRITE_SIZE = 16;
    localparam int unsigned TILE_SHIFT  = 4;
    localparam int unsigned MAP_W       = 40;
    localparam int unsigned MAP_H       = 30;
    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned X_W         = 10;
    localparam int unsigned Y_W         = 9;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StProbeA,
        StProbeB,
        StWaitB,
        StResp
    } state_e;

endpackage

// File: rtl/maze_move_checker_if.sv
// Request/response bundle between the movers and the shared move checker.
interface maze_move_checker_if #(
    parameter int unsigned NUM_REQ = 4
);
    import maze_pkg::*;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*X_W-1:0] req_x;
    logic [NUM_REQ*Y_W-1:0] req_y;
    logic [NUM_REQ*2-1:0]   req_dir;
    logic [NUM_REQ-1:0]     resp_valid;
    logic                   resp_pass;
    logic                   busy;

    modport master (
        output req_valid, req_x, req_y, req_dir,
        input  resp_valid, resp_pass, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, req_dir,
        output resp_valid, resp_pass, busy
    );

endinterface

// File: rtl/maze_move_checker_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);
    import maze_pkg::*;

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (en) begin
            // First pass covers [ptr, NUM_REQ), second pass the wrapped part below ptr.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/maze_move_checker.sv
// Shared wall-collision responder: probes two sprite corners of the next position in the
// tile ROM and answers pass/blocked to one round-robin-selected mover every five cycles.
module maze_move_checker #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SPRITE_SIZE = maze_pkg::SPRITE_SIZE,
    parameter int unsigned TILE_SHIFT  = maze_pkg::TILE_SHIFT,
    parameter int unsigned MAP_W       = maze_pkg::MAP_W,
    parameter int unsigned MAP_H       = maze_pkg::MAP_H,
    parameter int unsigned ADDR_W      = maze_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    maze_move_checker_if.slave  bus,
    output logic [ADDR_W-1:0]   map_addr,
    input  logic                map_data
);
    import maze_pkg::*;

    localparam int unsigned       IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [10:0]       S_X      = 11'(SPRITE_SIZE - 1);
    localparam logic [9:0]        S_Y      = 10'(SPRITE_SIZE - 1);
    localparam logic [10:0]       MAP_W_X  = 11'(MAP_W);
    localparam logic [9:0]        MAP_H_Y  = 10'(MAP_H);
    localparam logic [ADDR_W-1:0] MAP_W_A  = ADDR_W'(MAP_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, idx_q, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any, arb_en;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [1:0]         dir_q;
    logic               wall_a_q, wall_b_q;
    logic [10:0]        nx, ax, bx;
    logic [9:0]         ny, ay, by;
    logic               oob_a, oob_b;

    // Coordinates carry one extra bit so a step below zero shows up as a set MSB.
    function automatic logic corner_oob(logic [10:0] px, logic [9:0] py);
        return px[10] | py[9] | ((px >> TILE_SHIFT) >= MAP_W_X) | ((py >> TILE_SHIFT) >= MAP_H_Y);
    endfunction

    function automatic logic [ADDR_W-1:0] corner_addr(logic [10:0] px, logic [9:0] py);
        logic [ADDR_W-1:0] tx, ty;
        tx = ADDR_W'(px >> TILE_SHIFT);
        ty = ADDR_W'(py >> TILE_SHIFT);
        return ty * MAP_W_A + tx;
    endfunction

    assign arb_en  = (state_q == StIdle);
    assign gnt_any = |gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt_any) state_d = StProbeA;
            StProbeA: state_d = StProbeB;
            StProbeB: state_d = StWaitB;
            StWaitB:  state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= DIR_UP;
            wall_a_q <= 1'b0;
            wall_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (arb_en && gnt_any) begin
                idx_q <= gnt_idx;
                x_q   <= bus.req_x[int'(gnt_idx) * X_W +: X_W];
                y_q   <= bus.req_y[int'(gnt_idx) * Y_W +: Y_W];
                dir_q <= bus.req_dir[int'(gnt_idx) * 2 +: 2];
            end
            if (state_q == StProbeB) wall_a_q <= map_data;
            if (state_q == StWaitB)  wall_b_q <= map_data;
            if (state_q == StResp)   ptr_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        nx = {1'b0, x_q};
        ny = {1'b0, y_q};
        unique case (dir_q)
            DIR_UP:    ny = {1'b0, y_q} - 10'd1;
            DIR_DOWN:  ny = {1'b0, y_q} + 10'd1;
            DIR_LEFT:  nx = {1'b0, x_q} - 11'd1;
            DIR_RIGHT: nx = {1'b0, x_q} + 11'd1;
        endcase
        // Corner A is the leading edge's low corner, B its high corner.
        ax = nx + ((dir_q == DIR_RIGHT) ? S_X : 11'd0);
        ay = ny + ((dir_q == DIR_DOWN)  ? S_Y : 10'd0);
        bx = nx + ((dir_q != DIR_LEFT)  ? S_X : 11'd0);
        by = ny + ((dir_q != DIR_UP)    ? S_Y : 10'd0);
    end

    assign oob_a = corner_oob(ax, ay);
    assign oob_b = corner_oob(bx, by);

    always_comb begin
        map_addr = '0;
        if (state_q == StProbeA && !oob_a) map_addr = corner_addr(ax, ay);
        if (state_q == StProbeB && !oob_b) map_addr = corner_addr(bx, by);
    end

    always_comb begin
        bus.resp_valid = '0;
        if (state_q == StResp) bus.resp_valid[idx_q] = 1'b1;
    end

    assign bus.resp_pass = (state_q == StResp) & ~(wall_a_q | wall_b_q | oob_a | oob_b);
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_maze_move_checker.sv
// Bench for maze_move_checker: directed scenarios plus random traffic scored cycle by cycle
// against a behavioural model of the arbitration schedule and the corner/tile rules.
module tb_maze_move_checker;
    import maze_pkg::*;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [10:0] map_addr;
    logic        map_data;

    maze_move_checker_if #(.NUM_REQ(N)) bus ();

    maze_move_checker #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .map_addr (map_addr),
        .map_data (map_data)
    );

    bit walls [0:2047];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous tile ROM.
    always @(posedge clk) map_data <= walls[map_addr];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model of the service schedule.
    bit   pend = 1'b0;
    int   m_ptr = 0, m_g = 0, m_grant_cyc = 0, m_resp_cyc = 0, free_cyc = 0;
    bit   m_pass;
    int   m_addr_a, m_addr_b;
    logic [3:0] hold_mask = 4'b0000;

    logic [3:0]  obs_rv;
    logic        obs_pass, obs_busy;
    logic [10:0] obs_addr;
    logic [3:0]  rec [0:19];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit corner_wall(input int px, input int py, output int addr);
        if (px < 0 || py < 0 || px / 16 >= 40 || py / 16 >= 30) begin
            addr = 0;
            return 1'b1;
        end
        addr = (py / 16) * 40 + px / 16;
        return walls[addr];
    endfunction

    function automatic void model_probe(input int x, input int y, input int d,
                                        output bit pass, output int aa, output int ab);
        int nx, ny, ax, ay, bx, by;
        bit wa, wb;
        nx = x;
        ny = y;
        case (d)
            0: ny = y - 1;
            1: ny = y + 1;
            2: nx = x - 1;
            default: nx = x + 1;
        endcase
        case (d)
            0:       begin ax = nx;      ay = ny;      bx = nx + 15; by = ny;      end
            1:       begin ax = nx;      ay = ny + 15; bx = nx + 15; by = ny + 15; end
            2:       begin ax = nx;      ay = ny;      bx = nx;      by = ny + 15; end
            default: begin ax = nx + 15; ay = ny;      bx = nx + 15; by = ny + 15; end
        endcase
        wa = corner_wall(ax, ay, aa);
        wb = corner_wall(bx, by, ab);
        pass = !(wa || wb);
    endfunction

    task automatic tick();
        logic [3:0] exp_rv, drop;
        bit in_resp, found;
        int j;
        @(negedge clk);
        obs_rv   = bus.resp_valid;
        obs_pass = bus.resp_pass;
        obs_busy = bus.busy;
        obs_addr = map_addr;
        in_resp  = pend && (cyc == m_resp_cyc);
        if (chk_en) begin
            exp_rv = in_resp ? (4'b0001 << m_g) : 4'b0000;
            check_eq("resp_valid", 32'(obs_rv), 32'(exp_rv));
            if (in_resp) check_eq("resp_pass", 32'(obs_pass), 32'(m_pass));
            else check_eq("busy", 32'(obs_busy), 32'(pend && cyc > m_grant_cyc));
            if (pend && cyc == m_grant_cyc + 1) check_eq("addr_a", 32'(obs_addr), 32'(m_addr_a));
            if (pend && cyc == m_grant_cyc + 2) check_eq("addr_b", 32'(obs_addr), 32'(m_addr_b));
        end
        if (in_resp) begin
            pend  = 1'b0;
            m_ptr = (m_g + 1) % N;
        end
        if (rst) begin
            pend     = 1'b0;
            m_ptr    = 0;
            free_cyc = cyc + 1;
        end else if (!pend && cyc >= free_cyc && |bus.req_valid) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && bus.req_valid[j]) begin
                    found = 1'b1;
                    m_g   = j;
                end
            end
            model_probe(int'(bus.req_x[m_g*10 +: 10]), int'(bus.req_y[m_g*9 +: 9]),
                        int'(bus.req_dir[m_g*2 +: 2]), m_pass, m_addr_a, m_addr_b);
            pend        = 1'b1;
            m_grant_cyc = cyc;
            m_resp_cyc  = cyc + 4;
            free_cyc    = cyc + 5;
        end
        drop = obs_rv & ~hold_mask;
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid = bus.req_valid & ~drop;
    endtask

    task automatic set_req(input int i, input int x, input int y, input logic [1:0] d);
        bus.req_x[i*10 +: 10] = 10'(x);
        bus.req_y[i*9 +: 9]   = 9'(y);
        bus.req_dir[i*2 +: 2] = d;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic run_record(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            rec[k] = obs_rv;
        end
    endtask

    function automatic int rand_x();
        if ($urandom_range(0, 7) == 0) return 0;
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 1023));
        return int'($urandom_range(0, 640));
    endfunction

    function automatic int rand_y();
        if ($urandom_range(0, 7) == 0) return 0;
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 511));
        return int'($urandom_range(0, 480));
    endfunction

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_dir   = '0;
        for (int a = 0; a < 2048; a++) walls[a] = 1'b0;

        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();
        check_eq("rst_resp_valid", 32'(obs_rv), 32'd0);
        check_eq("rst_busy", 32'(obs_busy), 32'd0);
        check_eq("rst_pass", 32'(obs_pass), 32'd0);
        check_eq("rst_addr", 32'(obs_addr), 32'd0);

        // Empty map, moving up from (45,45).
        set_req(0, 45, 45, DIR_UP);
        tick();
        tick(); check_eq("t1_addr_a", 32'(obs_addr), 32'd82);
        tick(); check_eq("t1_addr_b", 32'(obs_addr), 32'd83);
        tick();
        tick(); check_eq("t1_rv", 32'(obs_rv), 32'b0001);
        check_eq("t1_pass", 32'(obs_pass), 32'd1);

        // Wall at tile (3,2), moving right.
        walls[83] = 1'b1;
        set_req(1, 32, 45, DIR_RIGHT);
        tick();
        tick(); check_eq("t2_addr_a", 32'(obs_addr), 32'd83);
        tick(); check_eq("t2_addr_b", 32'(obs_addr), 32'd123);
        tick();
        tick(); check_eq("t2_rv", 32'(obs_rv), 32'b0010);
        check_eq("t2_pass", 32'(obs_pass), 32'd0);

        // Left underflow, then bottom edge out of map.
        set_req(2, 0, 100, DIR_LEFT);
        tick();
        tick(); check_eq("t3_addr_oob", 32'(obs_addr), 32'd0);
        repeat (2) tick();
        tick(); check_eq("t3_rv", 32'(obs_rv), 32'b0100);
        check_eq("t3_pass", 32'(obs_pass), 32'd0);
        set_req(3, 200, 464, DIR_DOWN);
        repeat (4) tick();
        tick(); check_eq("t3b_rv", 32'(obs_rv), 32'b1000);
        check_eq("t3b_pass", 32'(obs_pass), 32'd0);

        // Simultaneous requests, pointer at 0 then at 3.
        set_req(0, 45, 45, DIR_UP);
        set_req(2, 100, 100, DIR_RIGHT);
        run_record(10);
        check_eq("t4_first", 32'(rec[4]), 32'b0001);
        check_eq("t4_second", 32'(rec[9]), 32'b0100);
        set_req(0, 300, 200, DIR_DOWN);
        set_req(1, 48, 40, DIR_LEFT);
        run_record(10);
        check_eq("t4_wrap_first", 32'(rec[4]), 32'b0001);
        check_eq("t4_wrap_second", 32'(rec[9]), 32'b0010);

        // Reset while waiting on the second probe.
        set_req(2, 45, 45, DIR_DOWN);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("t5_rv", 32'(obs_rv), 32'd0);
        check_eq("t5_busy", 32'(obs_busy), 32'd0);
        check_eq("t5_pass", 32'(obs_pass), 32'd0);
        check_eq("t5_addr", 32'(obs_addr), 32'd0);
        repeat (3) tick();
        tick(); check_eq("t5_reserve", 32'(obs_rv), 32'b0100);

        // Two requesters holding their level.
        hold_mask = 4'b0011;
        set_req(0, 45, 45, DIR_UP);
        set_req(1, 32, 45, DIR_RIGHT);
        run_record(20);
        check_eq("t6_r0", 32'(rec[4]), 32'b0001);
        check_eq("t6_r1", 32'(rec[9]), 32'b0010);
        check_eq("t6_r2", 32'(rec[14]), 32'b0001);
        check_eq("t6_r3", 32'(rec[19]), 32'b0010);
        hold_mask     = 4'b0000;
        bus.req_valid = '0;
        tick();

        // Random traffic on a random map.
        for (int a = 0; a < 1200; a++) walls[a] = ($urandom_range(0, 9) < 3);
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, rand_x(), rand_y(), 2'($urandom_range(0, 3)));
            end
            // Inputs of the requester in service are latched, so disturbing them is harmless.
            if (pend && cyc > m_grant_cyc && $urandom_range(0, 7) == 0) begin
                bus.req_x[m_g*10 +: 10] = 10'($urandom_range(0, 1023));
                bus.req_y[m_g*9 +: 9]   = 9'($urandom_range(0, 511));
                bus.req_dir[m_g*2 +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) bus.req_valid[m_g] = 1'b0;
            end
        end
        rst           = 1'b0;
        bus.req_valid = '0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
